// File: rtl/frame_ram_reader.sv
// frame_ram_reader: walks one FRAME_W x FRAME_H frame out of a pseudo-dual-port RAM and emits it as a tagged pixel stream.
// Latency: first o_valid RD_LAT+1 cycles after the accepted i_start, then one pixel per cycle while i_ready stays high.
// Backpressure: i_ready low holds the FIFO head; reads are credit-limited (inflight + fifo_count < FIFO_DEPTH) so nothing overflows.
//
// Ports:
//   clk, rst_n          single clock (also the RAM read clock), asynchronous active-low reset
//   i_start/i_base_addr start pulse and frame base address, accepted only while idle
//   i_mirror            (only with FRAME_READER_MIRROR_EN) read each line right-to-left
//   o_busy/o_done       busy from accepted start to EOF handshake; done pulses the cycle after
//   ram_addr/ram_clk_en RAM read address (valid in the issue cycle) and read clock enable
//   ram_rd_data         RAM read data, valid RD_LAT cycles after its address
//   o_data/o_valid/i_ready/o_sof/o_eol/o_eof  valid/ready pixel stream with frame markers
//
// Optional feature macro: FRAME_READER_MIRROR_EN (adds i_mirror; default build has no mirror support).

// Small generic FIFO: circular buffer with occupancy count, head visible combinationally.
// Latency: a pushed word becomes visible at the head the cycle after the push (if the FIFO was empty).
// Backpressure: caller must not push when full; pop only happens when rd_rdy and not empty.
module frame_ram_reader_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_vld,
    input  logic [WIDTH-1:0]           wr_dat,
    output logic                       rd_vld,
    input  logic                       rd_rdy,
    output logic [WIDTH-1:0]           rd_dat,
    output logic [$clog2(DEPTH+1)-1:0] cnt
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push;
    logic             pop;

    always_comb begin
        push     = wr_vld;
        pop      = rd_rdy && (cnt_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        // simultaneous push and pop leaves the count unchanged
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wr_dat;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rd_vld = (cnt_q != '0);
    assign rd_dat = mem_q[rd_ptr_q];
    assign cnt    = cnt_q;
endmodule

module frame_ram_reader #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 18,
    parameter int FRAME_W    = 32,
    parameter int FRAME_H    = 24,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
`ifdef FRAME_READER_MIRROR_EN
    input  logic              i_mirror,
`endif
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_clk_en,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_sof,
    output logic              o_eol,
    output logic              o_eof
);
    localparam int X_W    = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int Y_W    = $clog2(FRAME_H + 1);   // y counts one past the last line
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + RD_LAT + 1);

    // The FIFO must hold everything that can be in flight plus the word being presented.
    if (FIFO_DEPTH < RD_LAT + 1) begin : g_depth_chk
        $error("frame_ram_reader: FIFO_DEPTH must be at least RD_LAT+1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } tag_t;

    typedef struct packed {
        tag_t              tag;
        logic [DATA_W-1:0] dat;
    } pix_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic              done_q, done_d;
    logic              clk_en_q, clk_en_d;
`ifdef FRAME_READER_MIRROR_EN
    logic              mirror_q, mirror_d;
`endif

    // Tag pipe runs alongside the RAM read latency; its last stage lines up with ram_rd_data.
    logic              pipe_vld_q [RD_LAT];
    logic              pipe_vld_d [RD_LAT];
    tag_t              pipe_tag_q [RD_LAT];
    tag_t              pipe_tag_d [RD_LAT];

    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  occupancy;
    logic [FCNT_W-1:0] fifo_cnt;
    logic              issue;
    logic              last_rd;
    logic              eof_hs;
    tag_t              cur_tag;
    logic [X_W-1:0]    x_col;
    logic [ADDR_W-1:0] rd_addr;
    pix_t              wr_pix;
    pix_t              head;
    logic              head_vld;

    // Credits: reads still travelling through the RAM plus words already queued.
    always_comb begin
        inflight = '0;
        for (int k = 0; k < RD_LAT; k++) begin
            inflight = inflight + CNT_W'(pipe_vld_q[k]);
        end
        occupancy = inflight + CNT_W'(fifo_cnt);
    end

    // Tags follow output order; only the column used for the address is mirrored.
    always_comb begin
        cur_tag.sof = (x_q == '0) && (y_q == '0);
        cur_tag.eol = (x_q == X_W'(FRAME_W - 1));
        cur_tag.eof = cur_tag.eol && (y_q == Y_W'(FRAME_H - 1));
        last_rd     = cur_tag.eof;
`ifdef FRAME_READER_MIRROR_EN
        x_col = mirror_q ? (X_W'(FRAME_W - 1) - x_q) : x_q;
`else
        x_col = x_q;
`endif
        // arithmetic is ADDR_W wide, so the address wraps silently past the top of the RAM
        rd_addr = base_q + (ADDR_W'(y_q) * ADDR_W'(FRAME_W)) + ADDR_W'(x_col);
    end

    // Next-state, counters and issue decision.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        x_d      = x_q;
        y_d      = y_q;
        done_d   = 1'b0;
        clk_en_d = 1'b1;
        issue    = 1'b0;
`ifdef FRAME_READER_MIRROR_EN
        mirror_d = mirror_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = RUN;
                    base_d  = i_base_addr;
                    x_d     = '0;
                    y_d     = '0;
`ifdef FRAME_READER_MIRROR_EN
                    mirror_d = i_mirror;
`endif
                end
            end
            RUN: begin
                if (occupancy < CNT_W'(FIFO_DEPTH)) begin
                    issue = 1'b1;
                    if (x_q == X_W'(FRAME_W - 1)) begin
                        x_d = '0;
                        y_d = y_q + Y_W'(1);
                    end else begin
                        x_d = x_q + X_W'(1);
                    end
                    if (last_rd) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (eof_hs) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        pipe_vld_d[0] = issue;
        pipe_tag_d[0] = cur_tag;
        for (int k = 1; k < RD_LAT; k++) begin
            pipe_vld_d[k] = pipe_vld_q[k-1];
            pipe_tag_d[k] = pipe_tag_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            base_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            done_q   <= 1'b0;
            clk_en_q <= 1'b0;
`ifdef FRAME_READER_MIRROR_EN
            mirror_q <= 1'b0;
`endif
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_vld_q[k] <= 1'b0;
                pipe_tag_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            x_q      <= x_d;
            y_q      <= y_d;
            done_q   <= done_d;
            clk_en_q <= clk_en_d;
`ifdef FRAME_READER_MIRROR_EN
            mirror_q <= mirror_d;
`endif
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_vld_q[k] <= pipe_vld_d[k];
                pipe_tag_q[k] <= pipe_tag_d[k];
            end
        end
    end

    // Capture: the credit check at issue time guarantees a free FIFO slot here.
    always_comb begin
        wr_pix.tag = pipe_tag_q[RD_LAT-1];
        wr_pix.dat = ram_rd_data;
    end

    frame_ram_reader_fifo #(
        .WIDTH ($bits(pix_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (pipe_vld_q[RD_LAT-1]),
        .wr_dat (wr_pix),
        .rd_vld (head_vld),
        .rd_rdy (i_ready),
        .rd_dat (head),
        .cnt    (fifo_cnt)
    );

    assign eof_hs     = head_vld && i_ready && head.tag.eof;
    assign o_valid    = head_vld;
    assign o_data     = head.dat;
    assign o_sof      = head.tag.sof;
    assign o_eol      = head.tag.eol;
    assign o_eof      = head.tag.eof;
    assign o_busy     = (state_q != IDLE);
    assign o_done     = done_q;
    assign ram_clk_en = clk_en_q;
    assign ram_addr   = issue ? rd_addr : '0;
endmodule

// File: tb/tb_frame_ram_reader.sv
// tb_frame_ram_reader: randomized bench for frame_ram_reader against a frame-order reference queue.
// Latency: models the RAM as a two-register read pipe on the DUT clock.
// Backpressure: drives i_ready with a configurable random duty cycle.
module tb_frame_ram_reader;
    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic [13:0] i_base_addr;
`ifdef FRAME_READER_MIRROR_EN
    logic        i_mirror;
`endif
    logic        o_busy;
    logic        o_done;
    logic [13:0] ram_addr;
    logic        ram_clk_en;
    logic [17:0] ram_rd_data;
    logic [17:0] o_data;
    logic        o_valid;
    logic        i_ready;
    logic        o_sof;
    logic        o_eol;
    logic        o_eof;

    int n_checks = 0;
    int n_errors = 0;
    int pix_cnt  = 0;
    int done_cnt = 0;
    int ready_pct = 100;

    logic [20:0] exp_q [$];     // {sof, eol, eof, data}
    logic [17:0] ram_mem [16384];
    logic [17:0] ram_s1;

    frame_ram_reader u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
`ifdef FRAME_READER_MIRROR_EN
        .i_mirror    (i_mirror),
`endif
        .o_busy      (o_busy),
        .o_done      (o_done),
        .ram_addr    (ram_addr),
        .ram_clk_en  (ram_clk_en),
        .ram_rd_data (ram_rd_data),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_sof       (o_sof),
        .o_eol       (o_eol),
        .o_eof       (o_eof)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM read port: array register then output register.
    always @(posedge clk) begin
        if (ram_clk_en) begin
            ram_s1      <= ram_mem[ram_addr];
            ram_rd_data <= ram_s1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: pixels leave in raster order; the address column flips when mirrored.
    task automatic push_frame(input logic [13:0] base, input bit mir);
        for (int y = 0; y < 24; y++) begin
            for (int x = 0; x < 32; x++) begin
                int col;
                logic [13:0] a;
                col = mir ? (31 - x) : x;
                a   = base + 14'(y * 32 + col);
                exp_q.push_back({(x == 0 && y == 0), (x == 31), (x == 31 && y == 23), 4'b0000, a});
            end
        end
    endtask

    task automatic start_frame(input logic [13:0] base, input bit mir);
        push_frame(base, mir);
        @(posedge clk);
        #1;
        i_start     = 1'b1;
        i_base_addr = base;
`ifdef FRAME_READER_MIRROR_EN
        i_mirror    = mir;
`endif
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string tag);
        for (int i = 0; i < 6000 && done_cnt == d0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_all_pixels"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_idle"}, 32'(o_busy), 32'd0);
    endtask

    task automatic wait_pixels(input int target, input string tag);
        for (int i = 0; i < 6000 && pix_cnt < target; i++) @(negedge clk);
        chk({tag, "_reached"}, 32'(pix_cnt >= target), 32'd1);
    endtask

    // i_ready driver
    initial begin
        i_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            i_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // Output monitor: scoreboard, hold-while-stalled and done-timing checks.
    initial begin
        logic        eof_hs_prev;
        logic        prev_stall;
        logic [20:0] prev_word;
        logic [20:0] word;
        logic [20:0] exp;
        eof_hs_prev = 1'b0;
        prev_stall  = 1'b0;
        prev_word   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                eof_hs_prev = 1'b0;
                prev_stall  = 1'b0;
            end else begin
                word = {o_sof, o_eol, o_eof, o_data};
                chk("done_timing", 32'(o_done), 32'(eof_hs_prev));
                if (prev_stall) begin
                    chk("hold_valid", 32'(o_valid), 32'd1);
                    chk("hold_word", 32'(word), 32'(prev_word));
                end
                if (o_valid && i_ready) begin
                    // all-ones word cannot occur in any frame, so it marks an unexpected pixel
                    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                    chk("pixel", 32'(word), 32'(exp));
                    pix_cnt++;
                end
                if (o_done) done_cnt++;
                eof_hs_prev = o_valid && i_ready && o_eof;
                prev_stall  = o_valid && !i_ready;
                prev_word   = word;
            end
        end
    end

    initial begin
        int d0;
        int p0;
        int lat;
        int span;
        for (int a = 0; a < 16384; a++) ram_mem[a] = 18'(a);
        rst_n       = 1'b0;
        i_start     = 1'b0;
        i_base_addr = '0;
`ifdef FRAME_READER_MIRROR_EN
        i_mirror    = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_clk_en", 32'(ram_clk_en), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_tags", 32'({o_sof, o_eol, o_eof}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("clk_en_after_rst", 32'(ram_clk_en), 32'd1);

        // 1: base 0x0100, ready high: latency, back-to-back span, single done
        ready_pct = 100;
        d0 = done_cnt;
        start_frame(14'h0100, 1'b0);
        lat = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (o_valid) break;
            lat++;
        end
        chk("t1_first_valid_lat", 32'(lat), 32'd3);
        chk("t1_busy", 32'(o_busy), 32'd1);
        span = 0;
        while (!(o_valid && i_ready && o_eof) && span < 3000) begin
            @(negedge clk);
            span++;
        end
        chk("t1_span", 32'(span), 32'd767);
        wait_done(d0, "t1");

        // 2: base near the top of the RAM: addresses wrap with no stall
        d0 = done_cnt;
        start_frame(14'h3FF0, 1'b0);
        for (int i = 0; i < 50 && !o_valid; i++) @(negedge clk);
        span = 0;
        while (!(o_valid && i_ready && o_eof) && span < 3000) begin
            @(negedge clk);
            span++;
        end
        chk("t2_span", 32'(span), 32'd767);
        wait_done(d0, "t2");

        // 3: random base, ~30% ready duty
        ready_pct = 30;
        d0 = done_cnt;
        start_frame(14'($urandom_range(0, 16383)), 1'b0);
        wait_done(d0, "t3");
        ready_pct = 100;

        // 4: second start mid-frame must be ignored
        d0 = done_cnt;
        p0 = pix_cnt;
        start_frame(14'h0100, 1'b0);
        wait_pixels(p0 + 100, "t4");
        @(posedge clk);
        #1;
        i_start     = 1'b1;
        i_base_addr = 14'h2000;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        wait_done(d0, "t4");

        // 5: reset mid-frame abandons it; a fresh frame follows cleanly
        ready_pct = 70;
        d0 = done_cnt;
        p0 = pix_cnt;
        start_frame(14'($urandom_range(0, 16383)), 1'b0);
        wait_pixels(p0 + 300, "t5");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_busy", 32'(o_busy), 32'd0);
        chk("t5_rst_valid", 32'(o_valid), 32'd0);
        chk("t5_rst_done", 32'(o_done), 32'd0);
        chk("t5_rst_out", 32'({o_sof, o_eol, o_eof, o_data}), 32'd0);
        chk("t5_rst_ram", 32'({ram_clk_en, ram_addr}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        ready_pct = 100;
        repeat (2) @(negedge clk);
        chk("t5_no_abort_done", 32'(done_cnt - d0), 32'd0);
        start_frame(14'h0000, 1'b0);
        wait_done(d0, "t5");

`ifdef FRAME_READER_MIRROR_EN
        // 6: mirrored read order
        ready_pct = 60;
        d0 = done_cnt;
        start_frame(14'h0000, 1'b1);
        wait_done(d0, "t6");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
